// File: rtl/fpga_logic_tile.sv
// Configurable logic tile: N K-input LUTs with per-input source crossbars and optional output flops,
// loaded through a bit-serial chain. Define FPGA_TILE_CFG_READBACK_EN to add the cfg_out readback port.
module fpga_logic_tile #(
  parameter int K = 4,
  parameter int N = 4,
  parameter int I = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [I-1:0] tile_in,
  input  logic         cfg_en,
  input  logic         cfg_data,
  output logic         cfg_done,
  output logic [N-1:0] tile_out
`ifdef FPGA_TILE_CFG_READBACK_EN
  ,
  output logic         cfg_out
`endif
);

  localparam int TT       = 1 << K;
  localparam int SEL_W    = $clog2(I + N);
  localparam int LUT_CFG  = TT + K * SEL_W + 1;
  localparam int CFG_BITS = N * LUT_CFG;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_r;
  logic [CFG_BITS-1:0] chain_r;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_base_s;
  logic [CNT_W-1:0]    count_next_s;
  logic [N-1:0]        q_r;
  logic [N-1:0]        comb_s;
  logic [N-1:0]        out_s;
  logic                cfg_done_r;

  // Feedback selects always read the flop, never the comb value, so no loops can form.
  function automatic logic src_bit(input logic [SEL_W-1:0] sel,
                                   input logic [I-1:0]     ins,
                                   input logic [N-1:0]     fb);
    logic v;
    v = 1'b0;
    for (int k = 0; k < I; k++) begin
      v = (sel == SEL_W'(k)) ? ins[k] : v;
    end
    for (int k = 0; k < N; k++) begin
      v = (sel == SEL_W'(I + k)) ? fb[k] : v;
    end
    return v;
  endfunction

  // Bit count after a shift: a shift from UNCFG or RUN always starts a fresh load.
  always_comb begin
    count_base_s = (state_r == LOAD) ? count_r : {CNT_W{1'b0}};
    count_next_s = count_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // LUT evaluation: gather the address from the crossbar, look up the truth table, pick comb or flop.
  always_comb begin : lut_eval
    logic [K-1:0]     addr;
    logic [SEL_W-1:0] sel;
    logic [TT-1:0]    truth;
    comb_s = {N{1'b0}};
    out_s  = {N{1'b0}};
    addr   = {K{1'b0}};
    sel    = {SEL_W{1'b0}};
    truth  = {TT{1'b0}};
    for (int j = 0; j < N; j++) begin
      truth = chain_r[j*LUT_CFG +: TT];
      for (int i = 0; i < K; i++) begin
        sel     = chain_r[j*LUT_CFG + TT + i*SEL_W +: SEL_W];
        addr[i] = src_bit(sel, tile_in, q_r);
      end
      comb_s[j] = truth[addr];
      out_s[j]  = chain_r[j*LUT_CFG + LUT_CFG - 1] ? q_r[j] : comb_s[j];
    end
  end

  // Load/run state machine with the config chain, bit counter and LUT flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r    <= {CFG_BITS{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      q_r        <= {N{1'b0}};
      state_r    <= UNCFG;
      cfg_done_r <= 1'b0;
    end else if (cfg_en) begin
      chain_r <= {cfg_data, chain_r[CFG_BITS-1:1]};
      q_r     <= {N{1'b0}};
      if (count_next_s == CNT_W'(CFG_BITS)) begin
        state_r    <= RUN;
        count_r    <= {CNT_W{1'b0}};
        cfg_done_r <= 1'b1;
      end else begin
        state_r    <= LOAD;
        count_r    <= count_next_s;
        cfg_done_r <= 1'b0;
      end
    end else begin
      case (state_r)
        RUN:     q_r <= comb_s;
        default: q_r <= {N{1'b0}};
      endcase
    end
  end

  // Outputs stay quiet until the tile holds a complete configuration.
  always_comb begin
    if (state_r == RUN) begin
      tile_out = out_s;
    end else begin
      tile_out = {N{1'b0}};
    end
  end

  assign cfg_done = cfg_done_r;

`ifdef FPGA_TILE_CFG_READBACK_EN
  assign cfg_out = chain_r[0];
`endif

endmodule

// File: tb/tb_fpga_logic_tile.sv
// Directed self-checking bench for fpga_logic_tile at default parameters (CFG_BITS = 132).
module tb_fpga_logic_tile;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tile_in = 8'h00;
  logic       cfg_en = 1'b0;
  logic       cfg_data = 1'b0;
  logic       cfg_done;
  logic [3:0] tile_out;
`ifdef FPGA_TILE_CFG_READBACK_EN
  logic       cfg_out;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [131:0] c2;
  logic [131:0] c3;

  fpga_logic_tile #(.K(4), .N(4), .I(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tile_in  (tile_in),
    .cfg_en   (cfg_en),
    .cfg_data (cfg_data),
    .cfg_done (cfg_done),
    .tile_out (tile_out)
`ifdef FPGA_TILE_CFG_READBACK_EN
    ,
    .cfg_out  (cfg_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift bits lo..hi-1 of v (bit 0 first), one per cycle, then drop cfg_en on the following negedge.
  task automatic shift_range(input logic [131:0] v, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      cfg_en   = 1'b1;
      cfg_data = v[i];
    end
    @(negedge clk);
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // LUT0 = AND of tile_in[3:0], comb output; other LUTs zero
    c2 = '0;
    c2[15:0]  = 16'h8000;
    c2[19:16] = 4'd0;
    c2[23:20] = 4'd1;
    c2[27:24] = 4'd2;
    c2[31:28] = 4'd3;
    c2[32]    = 1'b0;
    // LUT0 = NOT of its own flop, flop output; unused selects tied to constant 0
    c3 = '0;
    c3[15:0]  = 16'h5555;
    c3[19:16] = 4'd8;
    c3[23:20] = 4'd12;
    c3[27:24] = 4'd12;
    c3[31:28] = 4'd12;
    c3[32]    = 1'b1;

    // Test 1: reset and idle
    tile_in = 8'hFF;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_cfg_done", {7'd0, cfg_done}, 8'h00);
      check("t1_tile_out", {4'd0, tile_out}, 8'h00);
    end

    // Test 2: AND load, cfg_done exactly after the 132nd shift
    shift_range(c2, 0, 131);
    check("t2_done_at_131", {7'd0, cfg_done}, 8'h00);
    check("t2_out_at_131", {4'd0, tile_out}, 8'h00);
    shift_range(c2, 131, 132);
    check("t2_done_at_132", {7'd0, cfg_done}, 8'h01);
    tile_in = 8'h0F; #1;
    check("t2_in0F", {4'd0, tile_out}, 8'h01);
    tile_in = 8'h07; #1;
    check("t2_in07", {4'd0, tile_out}, 8'h00);
    tile_in = 8'hFF; #1;
    check("t2_inFF", {4'd0, tile_out}, 8'h01);
    tile_in = 8'hF0; #1;
    check("t2_inF0", {4'd0, tile_out}, 8'h00);

    // Test 3: toggle through own flop, sequence 0 then 1,0,1,0
    tile_in = 8'h00;
    shift_range(c3, 0, 132);
    check("t3_done", {7'd0, cfg_done}, 8'h01);
    check("t3_first", {4'd0, tile_out}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_toggle", {4'd0, tile_out}, (i % 2 == 0) ? 8'h01 : 8'h00);
    end

    // Test 5: reconfigure from RUN with a single shift, then complete with the AND config
    tile_in = 8'h0F;
    shift_range(c2, 0, 1);
    check("t5_done_low", {7'd0, cfg_done}, 8'h00);
    check("t5_out_low", {4'd0, tile_out}, 8'h00);
    shift_range(c2, 1, 131);
    check("t5_done_at_131", {7'd0, cfg_done}, 8'h00);
    shift_range(c2, 131, 132);
    check("t5_done_at_132", {7'd0, cfg_done}, 8'h01);
    #1;
    check("t5_in0F", {4'd0, tile_out}, 8'h01);
    tile_in = 8'h07; #1;
    check("t5_in07", {4'd0, tile_out}, 8'h00);

    // Test 6: reset in the middle of a load, full reload required
    shift_range(c3, 0, 70);
    do_reset();
    check("t6_done_rst", {7'd0, cfg_done}, 8'h00);
    check("t6_out_rst", {4'd0, tile_out}, 8'h00);
    shift_range(c2, 0, 131);
    check("t6_done_at_131", {7'd0, cfg_done}, 8'h00);
    shift_range(c2, 131, 132);
    check("t6_done_at_132", {7'd0, cfg_done}, 8'h01);
    tile_in = 8'h0F; #1;
    check("t6_in0F", {4'd0, tile_out}, 8'h01);

    // Test 4: pause of 10 cycles after bit 50
    do_reset();
    shift_range(c2, 0, 50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
    end
    check("t4_done_paused", {7'd0, cfg_done}, 8'h00);
    shift_range(c2, 50, 131);
    check("t4_done_at_131", {7'd0, cfg_done}, 8'h00);
    shift_range(c2, 131, 132);
    check("t4_done_at_132", {7'd0, cfg_done}, 8'h01);
    tile_in = 8'h0F; #1;
    check("t4_in0F", {4'd0, tile_out}, 8'h01);
    tile_in = 8'h07; #1;
    check("t4_in07", {4'd0, tile_out}, 8'h00);

`ifdef FPGA_TILE_CFG_READBACK_EN
    // Readback: shifting a new stream pushes out the AND config, bit 0 first
    for (int i = 0; i < 132; i++) begin
      @(negedge clk);
      check("rb_cfg_out", {7'd0, cfg_out}, {7'd0, c2[i]});
      cfg_en   = 1'b1;
      cfg_data = c3[i];
    end
    @(negedge clk);
    cfg_en = 1'b0;
    check("rb_done", {7'd0, cfg_done}, 8'h01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
